// File: rtl/load_unit_mc_if.sv
// Load-unit bundle: pipeline request/response, stall and data-memory read bus.
// "master" is the pipeline/memory side; "slave" is the load unit.
interface load_unit_mc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int OPC_WIDTH  = 6
);
  logic                  req_valid;
  logic                  req_ready;
  logic [OPC_WIDTH-1:0]  req_opcode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_rt_data;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_rdata;
  logic                  mem_ack;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_addr_err;
  logic                  resp_bus_err;
  logic                  stall_req;

  modport master (
    output req_valid, req_opcode, req_addr, req_rt_data, mem_rdata, mem_ack,
    input  req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_addr_err,
           resp_bus_err, stall_req
  );

  modport slave (
    input  req_valid, req_opcode, req_addr, req_rt_data, mem_rdata, mem_ack,
    output req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_addr_err,
           resp_bus_err, stall_req
  );
endinterface

// File: rtl/load_unit_mc.sv
// Multi-cycle MIPS load unit: fetches 1..4 big-endian beats over a MEM_WIDTH bus,
// then sign/zero-extends or lwl/lwr-merges the result for register write-back.
module load_unit_mc #(
  parameter int MEM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic           clk,
  input logic           rst,
  load_unit_mc_if.slave bus
);
  localparam int MEM_BYTES = MEM_WIDTH / 8;
  localparam int HALF_ALIGN = (MEM_BYTES > 2) ? MEM_BYTES : 2;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_known(input logic [5:0] opc);
    case (opc)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: is_known = 1'b1;
      default:                                             is_known = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] opc, input logic [1:0] lo);
    case (opc)
      OP_LH, OP_LHU: is_misaligned = lo[0];
      OP_LW:         is_misaligned = (lo != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

  // Index of the last beat (beat count minus one)
  function automatic logic [1:0] last_beat(input logic [5:0] opc);
    case (opc)
      OP_LB, OP_LBU:         last_beat = 2'd0;
      OP_LH, OP_LHU:         last_beat = (MEM_BYTES == 1) ? 2'd1 : 2'd0;
      OP_LW, OP_LWL, OP_LWR: last_beat = 2'(4 / MEM_BYTES - 1);
      default:               last_beat = 2'd0;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] start_addr(input logic [5:0] opc,
                                                      input logic [ADDR_WIDTH-1:0] a);
    case (opc)
      OP_LB, OP_LBU:         start_addr = a & ~ADDR_WIDTH'(MEM_BYTES - 1);
      OP_LH, OP_LHU:         start_addr = a & ~ADDR_WIDTH'(HALF_ALIGN - 1);
      OP_LW, OP_LWL, OP_LWR: start_addr = a & ~ADDR_WIDTH'(3);
      default:               start_addr = a;
    endcase
  endfunction

  // w holds the fetched unit right-justified; offset 0 is its most significant byte.
  function automatic logic [31:0] format_load(input logic [5:0]  opc,
                                              input logic [1:0]  n,
                                              input logic [31:0] w,
                                              input logic [31:0] rt);
    logic [1:0]  lane;
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [5:0]  rsh;
    logic [7:0]  b;
    logic [15:0] h;
    lane = n & 2'(MEM_BYTES - 1);
    bsh  = 5'(8 * (MEM_BYTES - 1 - int'(lane)));
    hsh  = ((MEM_BYTES == 4) && !n[1]) ? 5'd16 : 5'd0;
    rsh  = {1'b0, n, 3'b000} + 6'd8;
    b    = 8'(w >> bsh);
    h    = 16'(w >> hsh);
    case (opc)
      OP_LB:   format_load = {{24{b[7]}}, b};
      OP_LBU:  format_load = {24'd0, b};
      OP_LH:   format_load = {{16{h[15]}}, h};
      OP_LHU:  format_load = {16'd0, h};
      OP_LW:   format_load = w;
      OP_LWL:  format_load = (w << {n, 3'b000}) | (rt & ((32'd1 << {n, 3'b000}) - 32'd1));
      OP_LWR:  format_load = (rt & ~((32'd1 << rsh) - 32'd1)) | (w >> {~n, 3'b000});
      default: format_load = 32'd0;
    endcase
  endfunction

  state_e                state_q;
  logic [5:0]            opcode_q;
  logic [1:0]            addr_lo_q;
  logic [31:0]           rt_q;
  logic [1:0]            beat_q;
  logic [1:0]            last_q;
  logic [TW-1:0]         wait_q;
  logic [31:0]           asm_q;
  logic [31:0]           asm_d;
  logic [31+MEM_WIDTH:0] shift_s;
  logic                  mem_re_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_data_q;
  logic                  addr_err_q;
  logic                  bus_err_q;
  logic                  stall_s;

  // Next assembly value: shift the acknowledged beat in at the LSB end
  always_comb begin
    shift_s = {asm_q, bus.mem_rdata};
    asm_d   = shift_s[31:0];
  end

  // Stall while a request is pending in IDLE and throughout the memory access
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE:  stall_s = bus.req_valid;
      ST_ISSUE: stall_s = 1'b1;
      default:  stall_s = 1'b0;
    endcase
  end

  // Control FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      opcode_q     <= 6'd0;
      addr_lo_q    <= 2'd0;
      rt_q         <= 32'd0;
      beat_q       <= 2'd0;
      last_q       <= 2'd0;
      wait_q       <= '0;
      asm_q        <= 32'd0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      addr_err_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            opcode_q   <= bus.req_opcode;
            addr_lo_q  <= bus.req_addr[1:0];
            rt_q       <= bus.req_rt_data;
            beat_q     <= 2'd0;
            last_q     <= last_beat(bus.req_opcode);
            wait_q     <= '0;
            asm_q      <= 32'd0;
            mem_addr_q <= start_addr(bus.req_opcode, bus.req_addr);
            if (!is_known(bus.req_opcode)) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_data_q  <= 32'd0;
            end else if (is_misaligned(bus.req_opcode, bus.req_addr[1:0])) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_data_q  <= 32'd0;
              addr_err_q   <= 1'b1;
            end else begin
              state_q  <= ST_ISSUE;
              mem_re_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (bus.mem_ack) begin
            asm_q      <= asm_d;
            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(MEM_BYTES);
            wait_q     <= '0;
            if (beat_q == last_q) begin
              state_q      <= ST_DONE;
              mem_re_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_data_q  <= format_load(opcode_q, addr_lo_q, asm_d, rt_q);
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end else if ((TIMEOUT > 0) && (wait_q == TW'(TIMEOUT - 1))) begin
            state_q      <= ST_DONE;
            mem_re_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= 32'd0;
            bus_err_q    <= 1'b1;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          addr_err_q   <= 1'b0;
          bus_err_q    <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          mem_re_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          addr_err_q   <= 1'b0;
          bus_err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE) && !rst;
  assign bus.stall_req     = stall_s;
  assign bus.mem_re        = mem_re_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_addr_err = addr_err_q;
  assign bus.resp_bus_err  = bus_err_q;
endmodule

// File: tb/tb_load_unit_mc.sv
// Directed bench for load_unit_mc (MEM_WIDTH=16, TIMEOUT=4) against a byte-array memory model.
module tb_load_unit_mc;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  logic ack_en;
  logic [7:0]  mem_b [0:511];
  logic [31:0] beats [$];
  int pass_cnt;
  int total_cnt;

  int          r_lat;
  logic [31:0] r_data;
  logic        r_ae;
  logic        r_be;
  int          r_re;
  logic        r_stall_ok;
  logic        r_pulse_ok;

  load_unit_mc_if #(.ADDR_WIDTH(32), .MEM_WIDTH(16), .DATA_WIDTH(32), .OPC_WIDTH(6)) bus ();

  load_unit_mc #(.MEM_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    bus.mem_ack   = bus.mem_re & ack_en;
    bus.mem_rdata = {mem_b[bus.mem_addr[8:0]], mem_b[bus.mem_addr[8:0] + 9'd1]};
  end

  always @(posedge clk) begin
    if (bus.mem_re === 1'b1 && bus.mem_ack === 1'b1) beats.push_back(bus.mem_addr);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request, then wait (bounded) for its response pulse.
  task automatic run_load(input logic [5:0] opc, input logic [31:0] addr, input logic [31:0] rt);
    beats.delete();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_opcode = opc;
    bus.req_addr = addr;
    bus.req_rt_data = rt;
    #1;
    r_stall_ok = (bus.stall_req === 1'b1) && (bus.req_ready === 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    r_lat = -1; r_data = 32'hDEADBEEF; r_ae = 1'bx; r_be = 1'bx; r_re = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        r_lat = c; r_data = bus.resp_data; r_ae = bus.resp_addr_err; r_be = bus.resp_bus_err;
        if (bus.stall_req !== 1'b0 || bus.mem_re !== 1'b0 || bus.req_ready !== 1'b0) r_stall_ok = 1'b0;
        break;
      end
      if (bus.mem_re === 1'b1) r_re++;
      if (bus.stall_req !== 1'b1) r_stall_ok = 1'b0;
    end
    @(negedge clk);
    r_pulse_ok = (bus.resp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt += 3;
    if (bus.req_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.req_ready); else pass_cnt++;
    if (bus.mem_re !== 1'b0) $display("FAIL reset_mem_re got %b exp 0", bus.mem_re); else pass_cnt++;
    if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); else pass_cnt++;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total_cnt += 3;
    if (bus.req_ready !== 1'b1) $display("FAIL idle_ready got %b exp 1", bus.req_ready); else pass_cnt++;
    if (bus.stall_req !== 1'b0) $display("FAIL idle_stall got %b exp 0", bus.stall_req); else pass_cnt++;
    if (bus.resp_data !== 32'd0) $display("FAIL reset_data got %h exp 0", bus.resp_data); else pass_cnt++;
  endtask

  task automatic test_lb();
    run_load(OP_LB, 32'h101, 32'h0);
    total_cnt += 6;
    if (r_data !== 32'hFFFFFF99) $display("FAIL lb_data got %h exp ffffff99", r_data); else pass_cnt++;
    if (r_lat !== 2) $display("FAIL lb_latency got %0d exp 2", r_lat); else pass_cnt++;
    if (beats.size() !== 1) $display("FAIL lb_beats got %0d exp 1", beats.size()); else pass_cnt++;
    if (beats.size() > 0 && beats[0] !== 32'h100) $display("FAIL lb_beat_addr got %h exp 100", beats[0]); else pass_cnt++;
    if ({r_ae, r_be} !== 2'b00) $display("FAIL lb_flags got %b exp 00", {r_ae, r_be}); else pass_cnt++;
    if (r_pulse_ok !== 1'b1) $display("FAIL lb_pulse got %b exp 1", r_pulse_ok); else pass_cnt++;
  endtask

  task automatic test_lw();
    run_load(OP_LW, 32'h100, 32'h0);
    total_cnt += 6;
    if (r_data !== 32'h8899AABB) $display("FAIL lw_data got %h exp 8899aabb", r_data); else pass_cnt++;
    if (r_lat !== 3) $display("FAIL lw_latency got %0d exp 3", r_lat); else pass_cnt++;
    if (r_stall_ok !== 1'b1) $display("FAIL lw_stall got %b exp 1", r_stall_ok); else pass_cnt++;
    if (r_re !== 2) $display("FAIL lw_re_cycles got %0d exp 2", r_re); else pass_cnt++;
    if (beats.size() !== 2) $display("FAIL lw_beats got %0d exp 2", beats.size()); else pass_cnt++;
    if (beats.size() == 2 && (beats[0] !== 32'h100 || beats[1] !== 32'h102))
      $display("FAIL lw_beat_addrs got %h,%h exp 100,102", beats[0], beats[1]);
    else pass_cnt++;
  endtask

  task automatic test_formats();
    vec_t v [12];
    v[0]  = '{OP_LBU, 32'h100, 32'h0,        32'h00000088, 2};
    v[1]  = '{OP_LBU, 32'h107, 32'h0,        32'h00000005, 2};
    v[2]  = '{OP_LB,  32'h104, 32'h0,        32'h0000007F, 2};
    v[3]  = '{OP_LB,  32'h106, 32'h0,        32'hFFFFFFC3, 2};
    v[4]  = '{OP_LH,  32'h100, 32'h0,        32'hFFFF8899, 2};
    v[5]  = '{OP_LHU, 32'h102, 32'h0,        32'h0000AABB, 2};
    v[6]  = '{OP_LH,  32'h106, 32'h0,        32'hFFFFC305, 2};
    v[7]  = '{OP_LWL, 32'h101, 32'h11223344, 32'h99AABB44, 3};
    v[8]  = '{OP_LWR, 32'h101, 32'h11223344, 32'h11228899, 3};
    v[9]  = '{OP_LWL, 32'h103, 32'h11223344, 32'hBB223344, 3};
    v[10] = '{OP_LWR, 32'h100, 32'h11223344, 32'h11223388, 3};
    v[11] = '{OP_LWR, 32'h103, 32'h11223344, 32'h8899AABB, 3};
    for (int i = 0; i < 12; i++) begin
      run_load(v[i].opc, v[i].addr, v[i].rt);
      total_cnt += 3;
      if (r_data !== v[i].exp) $display("FAIL fmt%0d_data got %h exp %h", i, r_data, v[i].exp); else pass_cnt++;
      if (r_lat !== v[i].lat) $display("FAIL fmt%0d_latency got %0d exp %0d", i, r_lat, v[i].lat); else pass_cnt++;
      if ({r_ae, r_be} !== 2'b00) $display("FAIL fmt%0d_flags got %b exp 00", i, {r_ae, r_be}); else pass_cnt++;
    end
  endtask

  task automatic test_misaligned();
    logic [5:0]  opc [5];
    logic [31:0] adr [5];
    opc = '{OP_LW, OP_LW, OP_LW, OP_LH, OP_LHU};
    adr = '{32'h102, 32'h103, 32'h101, 32'h101, 32'h105};
    for (int i = 0; i < 5; i++) begin
      run_load(opc[i], adr[i], 32'hFFFFFFFF);
      total_cnt += 4;
      if ({r_ae, r_be} !== 2'b10) $display("FAIL mis%0d_flags got %b exp 10", i, {r_ae, r_be}); else pass_cnt++;
      if (r_data !== 32'd0) $display("FAIL mis%0d_data got %h exp 0", i, r_data); else pass_cnt++;
      if (r_lat !== 1) $display("FAIL mis%0d_latency got %0d exp 1", i, r_lat); else pass_cnt++;
      if (r_re !== 0 || beats.size() !== 0) $display("FAIL mis%0d_mem_access got %0d exp 0", i, r_re); else pass_cnt++;
    end
  endtask

  task automatic test_unknown();
    run_load(6'h0F, 32'h100, 32'h12345678);
    total_cnt += 4;
    if (r_data !== 32'd0) $display("FAIL unk_data got %h exp 0", r_data); else pass_cnt++;
    if ({r_ae, r_be} !== 2'b00) $display("FAIL unk_flags got %b exp 00", {r_ae, r_be}); else pass_cnt++;
    if (r_lat !== 1) $display("FAIL unk_latency got %0d exp 1", r_lat); else pass_cnt++;
    if (r_re !== 0) $display("FAIL unk_mem_re got %0d exp 0", r_re); else pass_cnt++;
  endtask

  task automatic test_timeout();
    ack_en = 1'b0;
    run_load(OP_LW, 32'h100, 32'h0);
    ack_en = 1'b1;
    total_cnt += 5;
    if ({r_ae, r_be} !== 2'b01) $display("FAIL to_flags got %b exp 01", {r_ae, r_be}); else pass_cnt++;
    if (r_data !== 32'd0) $display("FAIL to_data got %h exp 0", r_data); else pass_cnt++;
    if (r_lat !== 5) $display("FAIL to_latency got %0d exp 5", r_lat); else pass_cnt++;
    if (r_re !== 4) $display("FAIL to_re_cycles got %0d exp 4", r_re); else pass_cnt++;
    if (r_stall_ok !== 1'b1) $display("FAIL to_stall got %b exp 1", r_stall_ok); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = OP_LW; bus.req_addr = 32'h100; bus.req_rt_data = 32'h0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt += 1;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'h102)
      $display("FAIL rmid_second_beat got re=%b addr=%h exp re=1 addr=102", bus.mem_re, bus.mem_addr);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt += 2;
    if (bus.mem_re !== 1'b0) $display("FAIL rmid_mem_re got %b exp 0", bus.mem_re); else pass_cnt++;
    if (bus.resp_valid !== 1'b0) $display("FAIL rmid_resp got %b exp 0", bus.resp_valid); else pass_cnt++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    total_cnt += 1;
    if (seen !== 1'b0) $display("FAIL rmid_no_resp got %b exp 0", seen); else pass_cnt++;
    run_load(OP_LHU, 32'h102, 32'h0);
    total_cnt += 2;
    if (r_data !== 32'h0000AABB) $display("FAIL rmid_lhu_data got %h exp 0000aabb", r_data); else pass_cnt++;
    if (r_lat !== 2) $display("FAIL rmid_lhu_latency got %0d exp 2", r_lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   c;
    logic got1;
    logic got2;
    got1 = 1'b0; got2 = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_opcode = OP_LB; bus.req_addr = 32'h101; bus.req_rt_data = 32'h0;
    @(posedge clk);
    #1;
    bus.req_opcode = OP_LBU; bus.req_addr = 32'h103;
    c = 0;
    while (!got1 && c < 20) begin
      @(negedge clk);
      c++;
      if (bus.resp_valid === 1'b1) begin
        got1 = 1'b1;
        total_cnt += 3;
        if (bus.resp_data !== 32'hFFFFFF99) $display("FAIL b2b_first_data got %h exp ffffff99", bus.resp_data); else pass_cnt++;
        if (bus.req_ready !== 1'b0) $display("FAIL b2b_done_ready got %b exp 0", bus.req_ready); else pass_cnt++;
        if (bus.stall_req !== 1'b0) $display("FAIL b2b_done_stall got %b exp 0", bus.stall_req); else pass_cnt++;
      end
    end
    total_cnt += 1;
    if (!got1) $display("FAIL b2b_first_timeout got none exp response"); else pass_cnt++;
    @(negedge clk);
    total_cnt += 2;
    if (bus.req_ready !== 1'b1) $display("FAIL b2b_idle_ready got %b exp 1", bus.req_ready); else pass_cnt++;
    if (bus.stall_req !== 1'b1) $display("FAIL b2b_idle_stall got %b exp 1", bus.stall_req); else pass_cnt++;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    c = 0;
    while (!got2 && c < 20) begin
      @(negedge clk);
      c++;
      if (bus.resp_valid === 1'b1) begin
        got2 = 1'b1;
        total_cnt += 2;
        if (bus.resp_data !== 32'h000000BB) $display("FAIL b2b_second_data got %h exp 000000bb", bus.resp_data); else pass_cnt++;
        if (c !== 2) $display("FAIL b2b_second_latency got %0d exp 2", c); else pass_cnt++;
      end
    end
    total_cnt += 1;
    if (!got2) $display("FAIL b2b_second_timeout got none exp response"); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    ack_en = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_opcode = 6'd0;
    bus.req_addr = 32'd0;
    bus.req_rt_data = 32'd0;
    for (int i = 0; i < 512; i++) mem_b[i] = 8'h00;
    mem_b[9'h100] = 8'h88; mem_b[9'h101] = 8'h99; mem_b[9'h102] = 8'hAA; mem_b[9'h103] = 8'hBB;
    mem_b[9'h104] = 8'h7F; mem_b[9'h105] = 8'h01; mem_b[9'h106] = 8'hC3; mem_b[9'h107] = 8'h05;
    test_reset();
    test_lb();
    test_lw();
    test_formats();
    test_misaligned();
    test_unknown();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
